sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Two-requester arbiter sharing one single-port synchronous SRAM macro (WIDTH x DEPTH, 1-cycle read latency). It sits between the SRAM and two masters: requester 0 (the AHB-Lite SRAM wrapper's SRAM-side port) and requester 1 (a DMA/background port). It issues at most one SRAM access per cycle. Arbitration is round-robin with burst locking, so an AHB burst is not interleaved unless the burst-limit feature forces a release.

## Interface
- WIDTH, 32, data width
- DEPTH, 4096, SRAM words
- WIDTH_ADDR, $clog2(DEPTH), word-address width
- MAX_BURST, 16, maximum consecutive locked grants (used only with SRAM_ARB_BURST_LIMIT_EN)

- hclk  in  1  clock, all state on rising edge
- hresetn  in  1  asynchronous active-low reset
- req0 / req1  in  1  access request, held until granted
- we0 / we1  in  1  1 = write, 0 = read
- lock0 / lock1  in  1  keep ownership for the next access (burst in progress)
- addr0 / addr1  in  WIDTH_ADDR  word address
- wdata0 / wdata1  in  WIDTH  write data
- gnt0 / gnt1  out  1  combinational; access issued to SRAM this cycle
- rvalid0 / rvalid1  out  1  registered; read data valid this cycle
- rdata  out  WIDTH  shared read data (= sram_q), qualified by rvalidN
- sram_csn  out  1  chip select, active low
- sram_wen  out  1  write enable, active low
- sram_a  out  WIDTH_ADDR  SRAM address
- sram_d  out  WIDTH  SRAM write data
- sram_q  in  WIDTH  SRAM read data, valid one cycle after the read access

## Operation
- State: owner (0/1), locked flag, last_grant pointer, burst counter (log2(MAX_BURST)+1 bits), rvalid0/rvalid1 registers.
- Grant decision each cycle:
  - If locked and req[owner] is high: grant the owner.
  - Otherwise, if only one requester is asserting: grant that requester.
  - Otherwise, if both are asserting: grant !last_grant.
  - Otherwise: no grant.
- Exactly one of gnt0/gnt1 or neither; never both.
- On a granted cycle:
  - sram_csn=0, sram_wen=!weN, sram_a=addrN, sram_d=wdataN.
  - Update: owner<=N, last_grant<=N, locked<=lockN.
- Lock release:
  - Cycle without req[owner]: locked<=0.
  - Lock sampled low on a grant: next cycle arbitrates freely.
- No grant: sram_csn=1, sram_wen=1; sram_a and sram_d hold their last values (registered shadow), so no toggling.
- Read return: rvalidN<=gntN & !weN; rdata driven straight from sram_q.
- Requester contract: req, we, addr, wdata and lock stay stable while req is high and gnt is low. The arbiter does not check this.

## Timing
- Grant is same-cycle combinational from req and state; the SRAM samples at the end of the grant cycle.
- Write: committed at the rising edge ending cycle T (grant in T).
- Read: gnt in T; rvalidN=1 and rdata valid in T+1. Back-to-back reads give one result per cycle.
- Ownership switch costs zero idle cycles; the losing requester is granted the next cycle at the earliest.
- Simultaneous first requests after reset: last_grant resets to 1, so requester 0 wins.
- Read followed by a grant to the other requester: the rvalid goes to the original requester only.
- Reset (asynchronous, any time, including mid-burst):
  - gnt0=gnt1=0, rvalid0=rvalid1=0, sram_csn=1, sram_wen=1, sram_a=0, sram_d=0.
  - owner=0, locked=0, last_grant=1, counter=0.
  - A pending read result is discarded.
- The burst counter saturates; it cannot wrap.

## Configuration
- SRAM_ARB_BURST_LIMIT_EN defined:
  - The counter increments on each consecutive grant to the same owner and clears on an owner change or idle cycle.
  - When the counter equals MAX_BURST and the other requester is asserting, the lock is overridden: the other requester is granted and the counter clears.
  - The preempted owner keeps req high and resumes when re-granted.
- Undefined: the counter logic is removed and the lock is honoured indefinitely. A locked requester can starve the other; this is acceptable when bursts are bounded upstream (INCR16 max).

## Test plan
- Reset mid-activity: assert hresetn=0 during a read grant -> immediately gnt0=gnt1=0, sram_csn=1; no rvalid in the following cycle after release.
- Single write/read: req0 writes 32'hA5A5_0001 at addr 5, then reads addr 5 -> gnt0 same cycle, sram_wen=0 then 1; rvalid0 one cycle later with rdata=32'hA5A5_0001.
- Contention, no lock: req0 and req1 held high for 6 cycles -> grants alternate 0,1,0,1,0,1 starting with requester 0; sram_a follows.
- Locked burst: requester 0 issues an INCR4 (lock0=1 for the first 3 beats) while req1 is high -> gnt0 for 4 consecutive cycles, then gnt1.
- Burst limit (macro on, MAX_BURST=4): lock0 held for 10 beats with req1 high -> gnt0 x4, gnt1 x1, gnt0 resumes. With the macro off -> gnt0 x10, then gnt1.
- Read return routing: req0 reads addr 1 in cycle T, req1 granted a write in T+1 -> rvalid0=1 only in T+1, rvalid1 stays 0.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// ============================================================================
// sram_port_arbiter : round-robin, burst-locking arbiter for one single-port
//                     SRAM shared by two requesters. Optional burst limit is
//                     enabled with `define SRAM_ARB_BURST_LIMIT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_port_arbiter #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 4096,
    parameter int WIDTH_ADDR = $clog2(DEPTH),
    parameter int MAX_BURST  = 16
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic [WIDTH_ADDR-1:0] addr0,
    input  logic [WIDTH_ADDR-1:0] addr1,
    input  logic [WIDTH-1:0]      wdata0,
    input  logic [WIDTH-1:0]      wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [WIDTH-1:0]      rdata,
    output logic                  sram_csn,
    output logic                  sram_wen,
    output logic [WIDTH_ADDR-1:0] sram_a,
    output logic [WIDTH-1:0]      sram_d,
    input  logic [WIDTH-1:0]      sram_q
);

    logic                  r_owner;
    logic                  r_locked;
    logic                  r_last_grant;
    logic                  r_rvalid0;
    logic                  r_rvalid1;
    logic [WIDTH_ADDR-1:0] r_a;
    logic [WIDTH-1:0]      r_d;

    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_any;
    logic                  w_sel;
    logic                  w_req_owner;
    logic                  w_req_other;
    logic                  w_preempt;
    logic                  w_we;
    logic                  w_lock;
    logic [WIDTH_ADDR-1:0] w_addr;
    logic [WIDTH-1:0]      w_wdata;

    assign w_req_owner = r_owner ? req1 : req0;
    assign w_req_other = r_owner ? req0 : req1;

`ifdef SRAM_ARB_BURST_LIMIT_EN
    localparam int c_cnt_w = $clog2(MAX_BURST) + 1;

    logic [c_cnt_w-1:0] r_cnt;

    assign w_preempt = (r_cnt == c_cnt_w'(MAX_BURST)) && w_req_other;

    // Count consecutive grants to the current owner; a new owner's first
    // grant restarts the count at one. Saturates at MAX_BURST.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_cnt <= '0;
        end else if (!w_any) begin
            r_cnt <= '0;
        end else if ((w_sel == r_owner) && (r_cnt != '0)) begin
            if (r_cnt != c_cnt_w'(MAX_BURST)) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end else begin
            r_cnt <= c_cnt_w'(1);
        end
    end
`else
    localparam int c_unused_max_burst = MAX_BURST;

    assign w_preempt = 1'b0;
`endif

    // Grants are gated by reset so they drop the moment hresetn falls.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (hresetn) begin
            if (r_locked && w_req_owner && !w_preempt) begin
                w_gnt0 = !r_owner;
                w_gnt1 = r_owner;
            end else if (req0 && !req1) begin
                w_gnt0 = 1'b1;
            end else if (req1 && !req0) begin
                w_gnt1 = 1'b1;
            end else if (req0 && req1) begin
                w_gnt0 = r_last_grant;
                w_gnt1 = !r_last_grant;
            end
        end
    end

    assign w_any   = w_gnt0 | w_gnt1;
    assign w_sel   = w_gnt1;
    assign w_we    = w_sel ? we1    : we0;
    assign w_lock  = w_sel ? lock1  : lock0;
    assign w_addr  = w_sel ? addr1  : addr0;
    assign w_wdata = w_sel ? wdata1 : wdata0;

    assign gnt0     = w_gnt0;
    assign gnt1     = w_gnt1;
    assign rvalid0  = r_rvalid0;
    assign rvalid1  = r_rvalid1;
    assign rdata    = sram_q;
    assign sram_csn = !w_any;
    assign sram_wen = !(w_any && w_we);
    // Address and data keep their last values on idle cycles to avoid toggling.
    assign sram_a   = w_any ? w_addr  : r_a;
    assign sram_d   = w_any ? w_wdata : r_d;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_owner      <= 1'b0;
            r_locked     <= 1'b0;
            r_last_grant <= 1'b1;
            r_rvalid0    <= 1'b0;
            r_rvalid1    <= 1'b0;
            r_a          <= '0;
            r_d          <= '0;
        end else begin
            r_rvalid0 <= w_gnt0 && !we0;
            r_rvalid1 <= w_gnt1 && !we1;
            if (w_any) begin
                r_owner      <= w_sel;
                r_last_grant <= w_sel;
                r_locked     <= w_lock;
                r_a          <= w_addr;
                r_d          <= w_wdata;
            end else begin
                r_locked     <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// ============================================================================
// tb_sram_port_arbiter : directed vector table plus hand-written sequences.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sram_port_arbiter;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4096;
    localparam int AW    = 12;
    localparam int NV    = 17;

    logic            hclk = 1'b0;
    logic            hresetn;
    logic            req0, req1, we0, we1, lock0, lock1;
    logic [AW-1:0]   addr0, addr1;
    logic [WIDTH-1:0] wdata0, wdata1;
    logic            gnt0, gnt1, rvalid0, rvalid1;
    logic [WIDTH-1:0] rdata;
    logic            sram_csn, sram_wen;
    logic [AW-1:0]   sram_a;
    logic [WIDTH-1:0] sram_d;
    logic [WIDTH-1:0] sram_q;

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 hclk = ~hclk;

    sram_port_arbiter #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .WIDTH_ADDR(AW), .MAX_BURST(4)
    ) dut (
        .hclk(hclk), .hresetn(hresetn),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .sram_csn(sram_csn), .sram_wen(sram_wen),
        .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
    );

    // Behavioural single-port SRAM, one-cycle read latency.
    always @(posedge hclk) begin
        if (!sram_csn) begin
            if (!sram_wen) mem[sram_a] <= sram_d;
            else           sram_q <= mem[sram_a];
        end
    end

    typedef struct {
        logic r0, r1, w0, w1, l0, l1;
        logic [AW-1:0] a0, a1;
        logic g0, g1, wen;
        logic [AW-1:0] a;
        logic rv0, rv1;
        logic [WIDTH-1:0] rd;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic r0, r1, w0, w1, l0, l1,
                                input logic [AW-1:0] a0, a1,
                                input logic g0, g1, wen,
                                input logic [AW-1:0] a,
                                input logic rv0, rv1,
                                input logic [WIDTH-1:0] rd);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1; v.l0 = l0; v.l1 = l1;
        v.a0 = a0; v.a1 = a1; v.g0 = g0; v.g1 = g1; v.wen = wen; v.a = a;
        v.rv0 = rv0; v.rv1 = rv1; v.rd = rd;
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] wd0(input logic [AW-1:0] a);
        return 32'hA000_0000 | WIDTH'(a);
    endfunction

    function automatic logic [WIDTH-1:0] wd1(input logic [AW-1:0] a);
        return 32'hB000_0000 | WIDTH'(a);
    endfunction

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        hresetn = 1'b0;
        repeat (2) @(negedge hclk);
        hresetn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] exp_d;
        logic             exp_g1;
        logic             req1_pend;
        int               beat;

        // Contention, burst lock, idle hold and read-return routing.
        vecs[0]  = mk(0,0,0,0,0,0, 12'h000,12'h000, 0,0,1,12'h000, 0,0,32'h0);
        vecs[1]  = mk(1,1,1,1,0,0, 12'h010,12'h020, 1,0,0,12'h010, 0,0,32'h0);
        vecs[2]  = mk(1,1,1,1,0,0, 12'h010,12'h020, 0,1,0,12'h020, 0,0,32'h0);
        vecs[3]  = mk(1,1,1,1,0,0, 12'h010,12'h020, 1,0,0,12'h010, 0,0,32'h0);
        vecs[4]  = mk(1,1,1,1,0,0, 12'h010,12'h020, 0,1,0,12'h020, 0,0,32'h0);
        vecs[5]  = mk(1,1,1,1,0,0, 12'h010,12'h020, 1,0,0,12'h010, 0,0,32'h0);
        vecs[6]  = mk(1,1,1,1,0,0, 12'h010,12'h020, 0,1,0,12'h020, 0,0,32'h0);
        vecs[7]  = mk(0,0,0,0,0,0, 12'h000,12'h000, 0,0,1,12'h020, 0,0,32'h0);
        vecs[8]  = mk(1,1,1,0,1,0, 12'h030,12'h020, 1,0,0,12'h030, 0,0,32'h0);
        vecs[9]  = mk(1,1,1,0,1,0, 12'h031,12'h020, 1,0,0,12'h031, 0,0,32'h0);
        vecs[10] = mk(1,1,1,0,1,0, 12'h032,12'h020, 1,0,0,12'h032, 0,0,32'h0);
        vecs[11] = mk(1,1,1,0,0,0, 12'h033,12'h020, 1,0,0,12'h033, 0,0,32'h0);
        vecs[12] = mk(0,1,0,0,0,0, 12'h000,12'h020, 0,1,1,12'h020, 0,0,32'h0);
        vecs[13] = mk(0,0,0,0,0,0, 12'h000,12'h000, 0,0,1,12'h020, 0,1,32'hB000_0020);
        vecs[14] = mk(1,0,0,0,0,0, 12'h033,12'h000, 1,0,1,12'h033, 0,0,32'h0);
        vecs[15] = mk(0,1,0,1,0,0, 12'h000,12'h041, 0,1,0,12'h041, 1,0,32'hA000_0033);
        vecs[16] = mk(0,0,0,0,0,0, 12'h000,12'h000, 0,0,1,12'h041, 0,0,32'h0);

        do_reset();
        exp_d = '0;
        for (int i = 0; i < NV; i++) begin
            @(negedge hclk);
            req0 = vecs[i].r0; req1 = vecs[i].r1; we0 = vecs[i].w0; we1 = vecs[i].w1;
            lock0 = vecs[i].l0; lock1 = vecs[i].l1;
            addr0 = vecs[i].a0; addr1 = vecs[i].a1;
            wdata0 = wd0(vecs[i].a0); wdata1 = wd1(vecs[i].a1);
            if (vecs[i].g0) exp_d = wd0(vecs[i].a0);
            else if (vecs[i].g1) exp_d = wd1(vecs[i].a1);
            #1;
            chk($sformatf("v%0d gnt0", i), WIDTH'(gnt0), WIDTH'(vecs[i].g0));
            chk($sformatf("v%0d gnt1", i), WIDTH'(gnt1), WIDTH'(vecs[i].g1));
            chk($sformatf("v%0d csn", i), WIDTH'(sram_csn), WIDTH'(!(vecs[i].g0 || vecs[i].g1)));
            chk($sformatf("v%0d wen", i), WIDTH'(sram_wen), WIDTH'(vecs[i].wen));
            chk($sformatf("v%0d sram_a", i), WIDTH'(sram_a), WIDTH'(vecs[i].a));
            chk($sformatf("v%0d sram_d", i), sram_d, exp_d);
            chk($sformatf("v%0d rvalid0", i), WIDTH'(rvalid0), WIDTH'(vecs[i].rv0));
            chk($sformatf("v%0d rvalid1", i), WIDTH'(rvalid1), WIDTH'(vecs[i].rv1));
            if (vecs[i].rv0 || vecs[i].rv1)
                chk($sformatf("v%0d rdata", i), rdata, vecs[i].rd);
        end

        // Single write then read-back by requester 0.
        @(negedge hclk);
        idle_inputs();
        req0 = 1; we0 = 1; addr0 = 12'd5; wdata0 = 32'hA5A5_0001;
        #1;
        chk("wr gnt0", WIDTH'(gnt0), 32'd1);
        chk("wr wen", WIDTH'(sram_wen), 32'd0);
        @(negedge hclk);
        we0 = 0;
        #1;
        chk("rd gnt0", WIDTH'(gnt0), 32'd1);
        chk("rd wen", WIDTH'(sram_wen), 32'd1);
        @(negedge hclk);
        req0 = 0;
        #1;
        chk("rd rvalid0", WIDTH'(rvalid0), 32'd1);
        chk("rd rvalid1", WIDTH'(rvalid1), 32'd0);
        chk("rd rdata", rdata, 32'hA5A5_0001);

        // Ten-beat locked burst from requester 0 against a single-beat requester 1.
        do_reset();
        beat = 0;
        req1_pend = 1'b1;
        for (int c = 0; c < 11; c++) begin
            @(negedge hclk);
            req0 = (beat < 10); lock0 = (beat < 9); we0 = 1'b1;
            addr0 = AW'(beat); wdata0 = wd0(AW'(beat));
            req1 = req1_pend; we1 = 1'b1; addr1 = 12'h077; wdata1 = wd1(12'h077);
`ifdef SRAM_ARB_BURST_LIMIT_EN
            exp_g1 = (c == 4);
`else
            exp_g1 = (c == 10);
`endif
            #1;
            chk($sformatf("burst c%0d gnt0", c), WIDTH'(gnt0), WIDTH'(!exp_g1));
            chk($sformatf("burst c%0d gnt1", c), WIDTH'(gnt1), WIDTH'(exp_g1));
            if (gnt0) beat++;
            if (gnt1) req1_pend = 1'b0;
        end
        chk("burst beats", WIDTH'(beat), 32'd10);

        // Asynchronous reset while a read is being granted.
        @(negedge hclk);
        idle_inputs();
        req0 = 1; we0 = 0; addr0 = 12'd5;
        #1;
        chk("rst pre gnt0", WIDTH'(gnt0), 32'd1);
        #2;
        hresetn = 1'b0;
        #1;
        chk("rst gnt0", WIDTH'(gnt0), 32'd0);
        chk("rst gnt1", WIDTH'(gnt1), 32'd0);
        chk("rst csn", WIDTH'(sram_csn), 32'd1);
        chk("rst wen", WIDTH'(sram_wen), 32'd1);
        chk("rst sram_a", WIDTH'(sram_a), 32'd0);
        chk("rst sram_d", sram_d, 32'd0);
        chk("rst rvalid0", WIDTH'(rvalid0), 32'd0);
        @(negedge hclk);
        req0 = 0;
        hresetn = 1'b1;
        #1;
        chk("post rst rvalid0", WIDTH'(rvalid0), 32'd0);
        @(negedge hclk);
        #1;
        chk("post rst2 rvalid0", WIDTH'(rvalid0), 32'd0);
        chk("post rst2 rvalid1", WIDTH'(rvalid1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
